// File: rtl/sms_single_shot_bank.sv
// -----------------------------------------------------------------------------
// sms_single_shot_bank
//
// Bank of independent single-shot (monostable) channels. Each channel watches
// its trigger input for a rising edge. When that edge arrives while the
// channel's gate is open, the channel produces a clean pulse on its output.
// The pulse lasts exactly the programmed number of clock cycles.
//
// Each channel also supports:
//   - retriggering (per-channel mode bit),
//   - aborting the pulse when its gate drops,
//   - a sticky flag that records any qualified trigger that had to be ignored.
//
// Parameters:
//   CHANNELS  number of independent channels
//   CNT_W     width of the pulse-length field and of each down-counter
//   RECOVERY  idle (busy, output low) cycles after a normal pulse end, >= 1;
//             only meaningful when SMS_SS_RECOVERY_EN is defined
//
// Optional feature macro:
//   SMS_SS_RECOVERY_EN  adds a RECOVER state after each normally-ended pulse.
//                       During RECOVER, qualified triggers are rejected and
//                       flagged as missed.
//
// Ports:
//   x        in   system clock, all state changes on its rising edge
//   reset_n  in   synchronous active-low reset
//   b        in   per-channel trigger inputs (already synchronous to x)
//   c        in   per-channel gate: 1 = armed, 0 = inhibit / abort
//   mode     in   per-channel mode: 1 = retriggerable, 0 = non-retriggerable
//   width    in   pulse length in cycles, shared, sampled only at load
//   d        out  registered pulse outputs
//   busy     out  channel is ACTIVE (or RECOVER)
//   missed   out  sticky: a qualified trigger was ignored
// -----------------------------------------------------------------------------
module sms_single_shot_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int RECOVERY = 2
) (
  input  logic                x,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] b,
  input  logic [CHANNELS-1:0] c,
  input  logic [CHANNELS-1:0] mode,
  input  logic [CNT_W-1:0]    width,
  output logic [CHANNELS-1:0] d,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] missed
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

`ifdef SMS_SS_RECOVERY_EN
  // The recovery counter holds RECOVERY-1 down to 0.
  localparam int RCNT_W = (RECOVERY > 1) ? $clog2(RECOVERY) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RECOVERY - 1);
`else
  localparam int unusedRecovery = RECOVERY;
`endif

  logic [CHANNELS-1:0] r_bPrev;
  logic [CHANNELS-1:0] w_trig;
  logic                w_widthZero;
  logic [CNT_W-1:0]    w_loadCnt;

  // Previous trigger levels for edge detection. Reset sets them to all ones,
  // so a trigger that is already high when reset is released is not treated
  // as a new edge.
  always_ff @(posedge x) begin
    if (!reset_n) begin
      r_bPrev <= '1;
    end else begin
      r_bPrev <= b;
    end
  end

  // A qualified trigger is a rising edge seen while the gate is open.
  // The counter load value is shared by every channel.
  always_comb begin
    w_trig      = b & ~r_bPrev & c;
    w_widthZero = (width == '0);
    w_loadCnt   = width - CNT_W'(1);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gChannel

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_d;
    logic             w_dNext;
    logic             r_mode;
    logic             w_modeNext;
    logic             r_missed;
    logic             w_missedNext;
`ifdef SMS_SS_RECOVERY_EN
    logic [RCNT_W-1:0] r_rcnt;
    logic [RCNT_W-1:0] w_rcntNext;
`endif

    // Channel state register. A reset that lands mid-pulse aborts the pulse
    // at that same edge.
    always_ff @(posedge x) begin
      if (!reset_n) begin
        r_state  <= ST_IDLE;
        r_cnt    <= '0;
        r_d      <= 1'b0;
        r_mode   <= 1'b0;
        r_missed <= 1'b0;
`ifdef SMS_SS_RECOVERY_EN
        r_rcnt   <= '0;
`endif
      end else begin
        r_state  <= w_stateNext;
        r_cnt    <= w_cntNext;
        r_d      <= w_dNext;
        r_mode   <= w_modeNext;
        r_missed <= w_missedNext;
`ifdef SMS_SS_RECOVERY_EN
        r_rcnt   <= w_rcntNext;
`endif
      end
    end

    // Next-state logic.
    //
    // The mode bit is latched whenever the counter loads (initial trigger or
    // retrigger). Changing the mode input mid-pulse therefore has no effect
    // until the next load. The width is sampled the same way.
    //
    // In ACTIVE, r_cnt counts the remaining high cycles after the current
    // one. Loading it with width-1 at the trigger edge keeps d high for
    // exactly `width` edges.
    always_comb begin
      w_stateNext  = r_state;
      w_cntNext    = r_cnt;
      w_dNext      = r_d;
      w_modeNext   = r_mode;
      w_missedNext = r_missed;
`ifdef SMS_SS_RECOVERY_EN
      w_rcntNext   = r_rcnt;
`endif
      case (r_state)
        ST_IDLE: begin
          // A zero-width trigger is silently dropped and does not count as
          // missed.
          if (w_trig[g] && !w_widthZero) begin
            w_stateNext = ST_ACTIVE;
            w_cntNext   = w_loadCnt;
            w_dNext     = 1'b1;
            w_modeNext  = mode[g];
          end
        end

        ST_ACTIVE: begin
          if (!c[g]) begin
            // Gate drop aborts immediately. This takes priority over
            // everything else.
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
            w_dNext     = 1'b0;
          end else if (w_trig[g] && r_mode && !w_widthZero) begin
            // Retrigger: restart the count from this edge. d never drops,
            // even on the last cycle.
            w_cntNext  = w_loadCnt;
            w_dNext    = 1'b1;
            w_modeNext = mode[g];
          end else begin
            // A non-retriggerable channel records the ignored trigger and
            // keeps counting down as usual.
            if (w_trig[g] && !r_mode) begin
              w_missedNext = 1'b1;
            end
            if (r_cnt == '0) begin
              w_dNext = 1'b0;
`ifdef SMS_SS_RECOVERY_EN
              w_stateNext = ST_RECOVER;
              w_rcntNext  = RCNT_LOAD;
`else
              w_stateNext = ST_IDLE;
`endif
            end else begin
              w_cntNext = r_cnt - CNT_W'(1);
            end
          end
        end

`ifdef SMS_SS_RECOVERY_EN
        ST_RECOVER: begin
          // The channel reports busy for RECOVERY cycles. The edge that
          // finds r_rcnt at zero is the first edge after recovery completes,
          // so it behaves exactly like IDLE and can accept a new trigger.
          if (!c[g]) begin
            w_stateNext = ST_IDLE;
            w_rcntNext  = '0;
          end else if (r_rcnt != '0) begin
            if (w_trig[g]) begin
              w_missedNext = 1'b1;
            end
            w_rcntNext = r_rcnt - RCNT_W'(1);
          end else begin
            w_stateNext = ST_IDLE;
            if (w_trig[g] && !w_widthZero) begin
              w_stateNext = ST_ACTIVE;
              w_cntNext   = w_loadCnt;
              w_dNext     = 1'b1;
              w_modeNext  = mode[g];
            end
          end
        end
`endif

        default: begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
          w_dNext     = 1'b0;
        end
      endcase
    end

    assign d[g]      = r_d;
    assign busy[g]   = (r_state != ST_IDLE);
    assign missed[g] = r_missed;

  end : gChannel

endmodule

// File: tb/tb_sms_single_shot_bank.sv
// -----------------------------------------------------------------------------
// tb_sms_single_shot_bank
//
// Self-checking bench for sms_single_shot_bank (4 channels, 8-bit width).
//
// The reference model tracks, per channel:
//   - how many high cycles remain,
//   - how many recovery cycles remain,
//   - the latched mode,
//   - the sticky missed flag.
//
// The bench checks three kinds of stimulus:
//   - a vector table of hand-derived expectations,
//   - directed pulse-length sequences,
//   - randomized traffic.
// -----------------------------------------------------------------------------
module tb_sms_single_shot_bank;

  localparam int CH  = 4;
  localparam int CW  = 8;
  localparam int REC = 2;

  logic          x = 1'b0;
  logic          reset_n;
  logic [CH-1:0] b;
  logic [CH-1:0] c;
  logic [CH-1:0] mode;
  logic [CW-1:0] width;
  logic [CH-1:0] d;
  logic [CH-1:0] busy;
  logic [CH-1:0] missed;

  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per channel.
  int mHi[CH];
  int mRec[CH];
  bit mMode[CH];
  bit mMissed[CH];
  bit mPrev[CH];

  typedef struct {
    logic          rstN;
    logic [CH-1:0] b;
    logic [CH-1:0] c;
    logic [CH-1:0] mode;
    logic [CW-1:0] width;
    logic [CH-1:0] eD;
    logic [CH-1:0] eBusy;
    logic [CH-1:0] eMissed;
  } vec_t;

  vec_t vecs[20];

  sms_single_shot_bank #(
    .CHANNELS(CH),
    .CNT_W(CW),
    .RECOVERY(REC)
  ) dut (
    .x(x),
    .reset_n(reset_n),
    .b(b),
    .c(c),
    .mode(mode),
    .width(width),
    .d(d),
    .busy(busy),
    .missed(missed)
  );

  always #5 x = ~x;

  // Watchdog: guarantees the run ends even if something hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model update for one rising edge, using the inputs present at that edge.
  task automatic modelStep();
    for (int i = 0; i < CH; i++) begin
      bit trig;
      trig = b[i] && !mPrev[i] && c[i];
      if (!reset_n) begin
        mHi[i]     = 0;
        mRec[i]    = 0;
        mMode[i]   = 1'b0;
        mMissed[i] = 1'b0;
        mPrev[i]   = 1'b1;
      end else begin
        if (mHi[i] > 0) begin
          if (!c[i]) begin
            mHi[i] = 0;
          end else if (trig && mMode[i] && width != 0) begin
            mHi[i]   = int'(width);
            mMode[i] = mode[i];
          end else begin
            if (trig && !mMode[i]) mMissed[i] = 1'b1;
            mHi[i]--;
`ifdef SMS_SS_RECOVERY_EN
            if (mHi[i] == 0) mRec[i] = REC;
`endif
          end
        end else if (mRec[i] > 1) begin
          if (!c[i]) begin
            mRec[i] = 0;
          end else begin
            if (trig) mMissed[i] = 1'b1;
            mRec[i]--;
          end
        end else begin
          mRec[i] = 0;
          if (trig && width != 0) begin
            mHi[i]   = int'(width);
            mMode[i] = mode[i];
          end
        end
        mPrev[i] = b[i];
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [CH-1:0] eD;
    logic [CH-1:0] eB;
    logic [CH-1:0] eM;
    for (int i = 0; i < CH; i++) begin
      eD[i] = (mHi[i] > 0);
      eB[i] = (mHi[i] > 0) || (mRec[i] > 0);
      eM[i] = mMissed[i];
    end
    check({tag, " d"}, 32'(d), 32'(eD));
    check({tag, " busy"}, 32'(busy), 32'(eB));
    check({tag, " missed"}, 32'(missed), 32'(eM));
  endtask

  // Drive inputs just after an edge, advance one clock, then compare against
  // the model.
  task automatic applyStimulus(input logic r, input logic [CH-1:0] bb, input logic [CH-1:0] cc,
                               input logic [CH-1:0] mm, input logic [CW-1:0] ww, input string tag);
    reset_n = r;
    b       = bb;
    c       = cc;
    mode    = mm;
    width   = ww;
    @(posedge x);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int n;
    int rises;
    logic prevD;

    reset_n = 1'b0;
    b       = '0;
    c       = '1;
    mode    = '0;
    width   = '0;

    //            rst   b        c        mode     width  eD       eBusy    eMissed
    vecs[0]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 8'd5, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 8'd5, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 8'd5, 4'b0000, 4'b0000, 4'b0000};
    vecs[3]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 8'd3, 4'b0000, 4'b0000, 4'b0000};
    vecs[4]  = '{1'b1, 4'b0001, 4'b1111, 4'b0000, 8'd3, 4'b0001, 4'b0001, 4'b0000};
    vecs[5]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 8'd3, 4'b0001, 4'b0001, 4'b0000};
    vecs[6]  = '{1'b1, 4'b0001, 4'b1111, 4'b0000, 8'd3, 4'b0001, 4'b0001, 4'b0001};
    vecs[7]  = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 8'd3, 4'b0000, 4'b0000, 4'b0001};
    vecs[8]  = '{1'b1, 4'b0010, 4'b1111, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0001};
    vecs[9]  = '{1'b1, 4'b0000, 4'b1111, 4'b0100, 8'd2, 4'b0000, 4'b0000, 4'b0001};
    vecs[10] = '{1'b1, 4'b0100, 4'b1111, 4'b0100, 8'd2, 4'b0100, 4'b0100, 4'b0001};
    vecs[11] = '{1'b1, 4'b0000, 4'b1111, 4'b0100, 8'd2, 4'b0100, 4'b0100, 4'b0001};
    vecs[12] = '{1'b1, 4'b0100, 4'b1111, 4'b0100, 8'd2, 4'b0100, 4'b0100, 4'b0001};
    vecs[13] = '{1'b1, 4'b0000, 4'b1111, 4'b0100, 8'd2, 4'b0100, 4'b0100, 4'b0001};
    vecs[14] = '{1'b1, 4'b0000, 4'b1111, 4'b0100, 8'd2, 4'b0000, 4'b0000, 4'b0001};
    vecs[15] = '{1'b1, 4'b1000, 4'b0111, 4'b0100, 8'd2, 4'b0000, 4'b0000, 4'b0001};
    vecs[16] = '{1'b1, 4'b0000, 4'b1111, 4'b0100, 8'd2, 4'b0000, 4'b0000, 4'b0001};
    vecs[17] = '{1'b1, 4'b1000, 4'b1111, 4'b0100, 8'd2, 4'b1000, 4'b1000, 4'b0001};
    vecs[18] = '{1'b1, 4'b0000, 4'b0111, 4'b0100, 8'd2, 4'b0000, 4'b0000, 4'b0001};
    vecs[19] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 8'd2, 4'b0000, 4'b0000, 4'b0000};

`ifndef SMS_SS_RECOVERY_EN
    // Vector table (expectations assume the plain build, no RECOVER state).
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].b, vecs[i].c, vecs[i].mode, vecs[i].width,
                    $sformatf("table[%0d]", i));
      check($sformatf("table[%0d] vec d", i), 32'(d), 32'(vecs[i].eD));
      check($sformatf("table[%0d] vec busy", i), 32'(busy), 32'(vecs[i].eBusy));
      check($sformatf("table[%0d] vec missed", i), 32'(missed), 32'(vecs[i].eMissed));
    end
`endif

    // Reset with b[0] held high: no spurious trigger.
    // Then a zero-width trigger: no pulse and no missed flag.
    applyStimulus(1'b0, 4'b0001, 4'b1111, 4'b0000, 8'd5, "rstHigh");
    applyStimulus(1'b1, 4'b0001, 4'b1111, 4'b0000, 8'd5, "relHigh");
    check("release b high d0", 32'(d[0]), 32'd0);
    check("release b high missed0", 32'(missed[0]), 32'd0);
    applyStimulus(1'b1, 4'b0000, 4'b1111, 4'b0000, 8'd0, "w0 idle");
    applyStimulus(1'b1, 4'b0001, 4'b1111, 4'b0000, 8'd0, "w0 trig");
    check("width0 no pulse", 32'(d[0]), 32'd0);
    check("width0 no missed", 32'(missed[0]), 32'd0);
    applyStimulus(1'b1, 4'b0000, 4'b1111, 4'b0000, 8'd5, "A idle");

    // Channel 0, width 5, one-cycle trigger.
    n = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, (k == 0) ? 4'b0001 : 4'b0000, 4'b1111, 4'b0000, 8'd5, "A");
      if (d[0]) n++;
    end
    check("A pulse length", 32'(n), 32'd5);
    check("A missed0", 32'(missed[0]), 32'd0);

    // Channel 1, retriggerable, width 6, second trigger 3 cycles later.
    n = 0;
    rises = 0;
    prevD = 1'b0;
    for (int k = 0; k < 24; k++) begin
      applyStimulus(1'b1, (k == 0 || k == 3) ? 4'b0010 : 4'b0000, 4'b1111, 4'b0010, 8'd6, "B");
      if (d[1]) n++;
      if (d[1] && !prevD) rises++;
      prevD = d[1];
    end
    check("B retrigger length", 32'(n), 32'd9);
    check("B single continuous pulse", 32'(rises), 32'd1);

    // Channel 2, non-retriggerable, same double trigger.
    n = 0;
    for (int k = 0; k < 24; k++) begin
      applyStimulus(1'b1, (k == 0 || k == 3) ? 4'b0100 : 4'b0000, 4'b1111, 4'b0000, 8'd6, "C");
      if (d[2]) n++;
    end
    check("C pulse length", 32'(n), 32'd6);
    check("C missed2 set", 32'(missed[2]), 32'd1);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 4'b0000, 4'b1111, 4'b0000, 8'd6, "C hold");
    check("C missed2 sticky", 32'(missed[2]), 32'd1);

    // Channel 3, width 8, gate dropped at cycle 3, retrigger two cycles later.
    n = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, (k == 0) ? 4'b1000 : 4'b0000, 4'b1111, 4'b0000, 8'd8, "D");
      if (d[3]) n++;
    end
    check("D high before abort", 32'(n), 32'd3);
    applyStimulus(1'b1, 4'b0000, 4'b0111, 4'b0000, 8'd8, "D drop");
    check("D abort d3", 32'(d[3]), 32'd0);
    check("D abort busy3", 32'(busy[3]), 32'd0);
    applyStimulus(1'b1, 4'b0000, 4'b1111, 4'b0000, 8'd8, "D gap");
    n = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, (k == 0) ? 4'b1000 : 4'b0000, 4'b1111, 4'b0000, 8'd8, "D re");
      if (d[3]) n++;
    end
    check("D retrigger full length", 32'(n), 32'd8);

`ifdef SMS_SS_RECOVERY_EN
    // Recovery window, width 3: a trigger 1 cycle after d falls is refused.
    applyStimulus(1'b0, 4'b0000, 4'b1111, 4'b0000, 8'd3, "E rst");
    applyStimulus(1'b1, 4'b0001, 4'b1111, 4'b0000, 8'd3, "E trig");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 4'b0000, 4'b1111, 4'b0000, 8'd3, "E run");
    check("E d fell", 32'(d[0]), 32'd0);
    check("E busy in recover", 32'(busy[0]), 32'd1);
    applyStimulus(1'b1, 4'b0001, 4'b1111, 4'b0000, 8'd3, "E early");
    check("E early ignored d0", 32'(d[0]), 32'd0);
    check("E early missed0", 32'(missed[0]), 32'd1);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 4'b0000, 4'b1111, 4'b0000, 8'd3, "E idle");

    // Recovery window, width 3: a trigger 2 cycles after d falls is accepted.
    applyStimulus(1'b0, 4'b0000, 4'b1111, 4'b0000, 8'd3, "F rst");
    applyStimulus(1'b1, 4'b0001, 4'b1111, 4'b0000, 8'd3, "F trig");
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 4'b0000, 4'b1111, 4'b0000, 8'd3, "F run");
    applyStimulus(1'b1, 4'b0001, 4'b1111, 4'b0000, 8'd3, "F late");
    check("F late accepted d0", 32'(d[0]), 32'd1);
    check("F late missed0", 32'(missed[0]), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic          rr;
      logic [CH-1:0] cc;
      rr = ($urandom_range(0, 49) != 0);
      cc = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '1;
      applyStimulus(rr, CH'($urandom), cc, CH'($urandom), CW'($urandom_range(0, 7)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
